eth_vlg_rtx_tmr: RTL and testbench

ETH_VLG_RTX_TMR -- requirements
Module: eth_vlg_rtx_tmr

---
 rtl/eth_vlg_pkg.sv | 14 +
 rtl/eth_vlg_rtx_tmr.sv | 100 ++++++++++
 tb/tb_eth_vlg_rtx_tmr.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_vlg_pkg.sv
// Shared eth_vlg definitions reused by the ARP/TCP retransmission logic.
package eth_vlg_pkg;

    typedef enum logic {
        StIdle,
        StArmed
    } rtx_tmr_state_e;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int unsigned rtx_cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/eth_vlg_rtx_tmr.sv
// Retransmission timer: counts external ticks while armed, pulses retry on each
// timeout (with optional exponential backoff) and fail once the retries are used up.
module eth_vlg_rtx_tmr
    import eth_vlg_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 4,
    parameter int unsigned MAX_TIMEOUT   = 64,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned BACKOFF       = 1,
    localparam int unsigned RW           = rtx_cnt_width(MAX_RETRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    output logic          retry,
    output logic          fail,
    output logic          busy,
    output logic [RW-1:0] retry_cnt
);

    localparam int unsigned   CW         = rtx_cnt_width(MAX_TIMEOUT);
    localparam logic [CW-1:0] InitTmo    = CW'(TIMEOUT_TICKS);
    localparam logic [CW:0]   MaxTmoWide = (CW + 1)'(MAX_TIMEOUT);
    localparam logic [RW-1:0] MaxRetries = RW'(MAX_RETRIES);

    rtx_tmr_state_e state_q, state_d;
    logic [CW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]  cur_tmo_q, cur_tmo_d;
    logic [RW-1:0]  retry_cnt_q, retry_cnt_d;
    logic           retry_q, retry_d;
    logic           fail_q, fail_d;

    logic           expire;
    logic [CW:0]    tmo_dbl;

    assign expire  = (state_q == StArmed) && tick && (tick_cnt_q == cur_tmo_q - CW'(1));
    // One bit wider so doubling near MAX_TIMEOUT cannot wrap before saturation.
    assign tmo_dbl = {cur_tmo_q, 1'b0};

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        cur_tmo_d   = cur_tmo_q;
        retry_cnt_d = retry_cnt_q;
        retry_d     = 1'b0;
        fail_d      = 1'b0;

        if (stop) begin
            state_d = StIdle;
        end else if (start) begin
            state_d     = StArmed;
            tick_cnt_d  = '0;
            retry_cnt_d = '0;
            cur_tmo_d   = InitTmo;
        end else if ((state_q == StArmed) && tick) begin
            if (expire) begin
                tick_cnt_d = '0;
                if (retry_cnt_q < MaxRetries) begin
                    retry_d     = 1'b1;
                    retry_cnt_d = retry_cnt_q + RW'(1);
                    if (BACKOFF != 0) begin
                        cur_tmo_d = (tmo_dbl > MaxTmoWide) ? MaxTmoWide[CW-1:0]
                                                           : tmo_dbl[CW-1:0];
                    end
                end else begin
                    fail_d  = 1'b1;
                    state_d = StIdle;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            cur_tmo_q   <= InitTmo;
            retry_cnt_q <= '0;
            retry_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            cur_tmo_q   <= cur_tmo_d;
            retry_cnt_q <= retry_cnt_d;
            retry_q     <= retry_d;
            fail_q      <= fail_d;
        end
    end

    assign busy      = (state_q == StArmed);
    assign retry     = retry_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_eth_vlg_rtx_tmr.sv
// Bench for eth_vlg_rtx_tmr: two configurations share stimulus and are checked
// each cycle against a deadline-based reference model.
module tb_eth_vlg_rtx_tmr;

    logic clk = 1'b0;
    logic rst, tick, start, stop;

    logic       a_retry, a_fail, a_busy;
    logic [1:0] a_rcnt;
    logic       b_retry, b_fail, b_busy;
    logic [0:0] b_rcnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eth_vlg_rtx_tmr #(
        .TIMEOUT_TICKS(4),
        .MAX_TIMEOUT  (6),
        .MAX_RETRIES  (2),
        .BACKOFF      (1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .retry    (a_retry),
        .fail     (a_fail),
        .busy     (a_busy),
        .retry_cnt(a_rcnt)
    );

    eth_vlg_rtx_tmr #(
        .TIMEOUT_TICKS(4),
        .MAX_TIMEOUT  (8),
        .MAX_RETRIES  (0),
        .BACKOFF      (0)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .retry    (b_retry),
        .fail     (b_fail),
        .busy     (b_busy),
        .retry_cnt(b_rcnt)
    );

    // Reference model: ticks remaining until the next deadline, per configuration.
    int p_max[2] = '{6, 8};
    int p_ret[2] = '{2, 0};
    int p_bo[2]  = '{1, 0};
    bit m_armed[2];
    int m_left[2];
    int m_tmo[2];
    int m_rcnt[2];
    bit m_retry[2];
    bit m_fail[2];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        m_retry[k] = 1'b0;
        m_fail[k]  = 1'b0;
        if (!rst) begin
            m_armed[k] = 1'b0;
            m_tmo[k]   = 4;
            m_left[k]  = 4;
            m_rcnt[k]  = 0;
        end else if (stop) begin
            m_armed[k] = 1'b0;
        end else if (start) begin
            m_armed[k] = 1'b1;
            m_tmo[k]   = 4;
            m_left[k]  = 4;
            m_rcnt[k]  = 0;
        end else if (m_armed[k] && tick) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
                if (m_rcnt[k] < p_ret[k]) begin
                    m_retry[k] = 1'b1;
                    m_rcnt[k]  = m_rcnt[k] + 1;
                    if (p_bo[k] != 0)
                        m_tmo[k] = (2 * m_tmo[k] > p_max[k]) ? p_max[k] : 2 * m_tmo[k];
                    m_left[k] = m_tmo[k];
                end else begin
                    m_fail[k]  = 1'b1;
                    m_armed[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("a_busy", int'(a_busy), int'(m_armed[0]));
        check("a_retry", int'(a_retry), int'(m_retry[0]));
        check("a_fail", int'(a_fail), int'(m_fail[0]));
        check("a_rcnt", int'(a_rcnt), m_rcnt[0]);
        check("b_busy", int'(b_busy), int'(m_armed[1]));
        check("b_retry", int'(b_retry), int'(m_retry[1]));
        check("b_fail", int'(b_fail), int'(m_fail[1]));
        check("b_rcnt", int'(b_rcnt), m_rcnt[1]);
    endtask

    task automatic cycle(input bit st, input bit sp, input bit tk, input bit rs);
        start = st;
        stop  = sp;
        tick  = tk;
        rst   = rs;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    // Idle cycles with tick on every second cycle, n ticks in total.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    // Ticks every second cycle until dut_a pulses; nt = -1 if the bound expires.
    task automatic wait_pulse(output int nt, output int was_fail);
        bit done;
        done     = 1'b0;
        nt       = 0;
        was_fail = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            cycle(1'b0, 1'b0, (i % 2) == 1, 1'b1);
            if ((i % 2) == 1) nt++;
            if (a_retry || a_fail) begin
                was_fail = int'(a_fail);
                done     = 1'b1;
            end
        end
        if (!done) nt = -1;
    endtask

    int nt, wf;

    initial begin
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_rcnt", int'(a_rcnt), 0);

        // Full retry/backoff/fail sequence; dut_b fails on the first deadline.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("start_busy", int'(a_busy), 1);
        wait_pulse(nt, wf);
        check("bo_first_ticks", nt, 4);
        check("bo_first_kind", wf, 0);
        check("bo_first_rcnt", int'(a_rcnt), 1);
        check("nobo_fail", int'(b_fail), 1);
        check("nobo_no_retry", int'(b_retry), 0);
        wait_pulse(nt, wf);
        check("bo_second_ticks", nt, 6);
        check("bo_second_rcnt", int'(a_rcnt), 2);
        wait_pulse(nt, wf);
        check("bo_fail_ticks", nt, 6);
        check("bo_fail_kind", wf, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("after_fail_busy", int'(a_busy), 0);
        check("after_fail_rcnt", int'(a_rcnt), 2);

        // Stop after two ticks, then a long quiet stretch.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_ticks(2);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("stop_busy", int'(a_busy), 0);
        run_ticks(20);

        // Stop coincident with expiry.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_ticks(3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("stop_exp_retry", int'(a_retry), 0);
        check("stop_exp_busy", int'(a_busy), 0);

        // Start coincident with expiry restarts the countdown.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_ticks(3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("start_exp_retry", int'(a_retry), 0);
        check("start_exp_rcnt", int'(a_rcnt), 0);
        wait_pulse(nt, wf);
        check("restart_ticks", nt, 4);

        // Start and stop together from idle.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("start_stop_busy", int'(a_busy), 0);

        // Reset mid-countdown after one retry.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        wait_pulse(nt, wf);
        run_ticks(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("midrst_busy", int'(a_busy), 0);
        check("midrst_rcnt", int'(a_rcnt), 0);
        run_ticks(20);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(15) == 0, $urandom_range(39) == 0,
                  $urandom_range(1) == 1, $urandom_range(299) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
